// File: rtl/exec_output_queue.sv
// Execution-unit output stage: registered register-file write plus
// per-requestor response FIFOs with valid/ready handshake.
module exec_output_queue #(
    parameter int          NUM_PORTS  = 4,
    parameter int          TAG_W      = 2,
    parameter int          DATA_W     = 32,
    parameter int          REG_ADR_W  = 4,
    parameter int          BRANCH_W   = 16,
    parameter int          DEPTH      = 4,
    parameter logic [15:0] VALID_MASK = 16'h0660,
    parameter logic [3:0]  DATA_CMD   = 4'b1010,
    localparam int         PW         = $clog2(NUM_PORTS),
    localparam int         BW         = $clog2(BRANCH_W),
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:3]                    in_cmd,
    input  logic [0:PW+TAG_W-1]           in_tag,
    input  logic [0:DATA_W-1]             in_result,
    input  logic [0:REG_ADR_W]            in_result_reg,
    input  logic [0:BW]                   follow_branch,
    input  logic [0:BRANCH_W-1]           branch_data,
    output logic                          write_valid,
    output logic [0:REG_ADR_W-1]          write_adr,
    output logic [0:DATA_W-1]             write_data,
    output logic [0:NUM_PORTS-1]          out_valid,
    input  logic [0:NUM_PORTS-1]          out_ready,
    output logic [0:2*NUM_PORTS-1]        out_resp,
    output logic [0:TAG_W*NUM_PORTS-1]    out_tag,
    output logic [0:DATA_W*NUM_PORTS-1]   out_data,
    output logic                          drop_cmd
);
    localparam int EW = 2 + TAG_W + DATA_W;

    logic                 w_valid;
    logic                 w_skip;
    logic                 w_fire;
    logic                 w_enq;
    logic [BW-1:0]        w_bidx;
    logic [PW-1:0]        w_port;
    logic [TAG_W-1:0]     w_subtag;
    logic [1:0]           w_resp;
    logic [DATA_W-1:0]    w_qdata;
    logic [EW-1:0]        w_entry;
    logic [EW-1:0]        w_head;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;

    logic [AW:0]   r_wr_ptr [NUM_PORTS];
    logic [AW:0]   r_rd_ptr [NUM_PORTS];
    logic [AW:0]   r_cnt    [NUM_PORTS];
    logic [EW-1:0] r_mem    [NUM_PORTS][DEPTH];

    function automatic logic [AW:0] f_next(input logic [AW:0] ptr);
        return {1'b0, ptr[AW-1:0] + AW'(1)};
    endfunction

    assign w_valid  = VALID_MASK[in_cmd];
    assign w_bidx   = follow_branch[1:BW];
    assign w_skip   = follow_branch[0] && branch_data[w_bidx];
    assign w_port   = in_tag[0:PW-1];
    assign w_subtag = in_tag[PW:PW+TAG_W-1];
    assign w_resp   = w_skip ? 2'b11 : 2'b01;
    assign w_qdata  = (!w_skip && in_cmd == DATA_CMD) ? in_result : '0;
    assign w_entry  = {w_resp, w_subtag, w_qdata};

    // Fullness comes from registered count only, so a pop never frees a slot early
    assign in_ready = !w_valid || !w_full[w_port];
    assign w_fire   = in_valid && in_ready;
    assign w_enq    = w_fire && w_valid;

    always_comb begin
        w_full   = '0;
        w_pop    = '0;
        w_head   = '0;
        out_valid = '0;
        out_resp = '0;
        out_tag  = '0;
        out_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_full[p]    = (r_cnt[p] == (AW+1)'(DEPTH));
            out_valid[p] = (r_cnt[p] != '0);
            w_pop[p]     = out_valid[p] && out_ready[p];
            if (out_valid[p]) begin
                w_head = r_mem[p][r_rd_ptr[p][AW-1:0]];
                out_resp[2*p +: 2]              = w_head[EW-1 -: 2];
                out_tag[TAG_W*p +: TAG_W]       = w_head[DATA_W +: TAG_W];
                out_data[DATA_W*p +: DATA_W]    = w_head[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        w_push = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_push[p] = w_enq && (w_port == PW'(p));
        end
    end

    always_ff @(negedge c_clk or posedge reset) begin
        if (reset) begin
            write_valid <= 1'b0;
            write_adr   <= '0;
            write_data  <= '0;
            drop_cmd    <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_wr_ptr[p] <= '0;
                r_rd_ptr[p] <= '0;
                r_cnt[p]    <= '0;
            end
        end else begin
            write_valid <= w_enq && in_result_reg[0] && !w_skip;
            write_adr   <= w_enq ? in_result_reg[1:REG_ADR_W] : '0;
            write_data  <= (w_enq && !w_skip) ? in_result : '0;
            drop_cmd    <= w_fire && !w_valid;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_push[p]) r_wr_ptr[p] <= f_next(r_wr_ptr[p]);
                if (w_pop[p])  r_rd_ptr[p] <= f_next(r_rd_ptr[p]);
                case ({w_push[p], w_pop[p]})
                    2'b10:   r_cnt[p] <= r_cnt[p] + (AW+1)'(1);
                    2'b01:   r_cnt[p] <= r_cnt[p] - (AW+1)'(1);
                    default: r_cnt[p] <= r_cnt[p];
                endcase
            end
        end
    end

    always_ff @(negedge c_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_push[p]) r_mem[p][r_wr_ptr[p][AW-1:0]] <= w_entry;
        end
    end
endmodule

// File: tb/tb_exec_output_queue.sv
// Directed bench for exec_output_queue: vector table plus
// multi-cycle sequences for backpressure and mid-run reset.
module tb_exec_output_queue;
    logic        c_clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [0:3]  in_cmd;
    logic [0:3]  in_tag;
    logic [0:31] in_result;
    logic [0:4]  in_result_reg;
    logic [0:4]  follow_branch;
    logic [0:15] branch_data;
    logic        write_valid;
    logic [0:3]  write_adr;
    logic [0:31] write_data;
    logic [0:3]  out_valid;
    logic [0:3]  out_ready;
    logic [0:7]  out_resp;
    logic [0:7]  out_tag;
    logic [0:127] out_data;
    logic        drop_cmd;

    int checks;
    int failures;

    exec_output_queue dut (
        .c_clk(c_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_tag(in_tag),
        .in_result(in_result), .in_result_reg(in_result_reg),
        .follow_branch(follow_branch), .branch_data(branch_data),
        .write_valid(write_valid), .write_adr(write_adr),
        .write_data(write_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_resp(out_resp),
        .out_tag(out_tag), .out_data(out_data),
        .drop_cmd(drop_cmd)
    );

    initial c_clk = 1'b1;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic        v;
        logic [3:0]  cmd;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [4:0]  rreg;
        logic [4:0]  fb;
        logic [15:0] bd;
        logic        e_rdy;
        logic        e_wv;
        logic [3:0]  e_adr;
        logic [31:0] e_wd;
        logic        e_drop;
        int          e_port;
        logic [1:0]  e_resp;
        logic [1:0]  e_tag;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] cmd,
                         input logic [3:0] tag, input logic [31:0] res,
                         input logic [4:0] rreg, input logic [4:0] fb,
                         input logic [15:0] bd);
        in_valid      = v;
        in_cmd        = cmd;
        in_tag        = tag;
        in_result     = res;
        in_result_reg = rreg;
        follow_branch = fb;
        branch_data   = bd;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_wv"}, 128'(write_valid), 128'(0));
        chk({nm, "_adr"}, 128'(write_adr), 128'(0));
        chk({nm, "_wd"}, 128'(write_data), 128'(0));
        chk({nm, "_drop"}, 128'(drop_cmd), 128'(0));
        chk({nm, "_ov"}, 128'(out_valid), 128'(0));
        chk({nm, "_resp"}, 128'(out_resp), 128'(0));
        chk({nm, "_tag"}, 128'(out_tag), 128'(0));
        chk({nm, "_data"}, out_data, 128'(0));
    endtask

    logic [0:3]   x_ov;
    logic [0:7]   x_resp;
    logic [0:7]   x_tag;
    logic [0:127] x_data;
    logic [1:0]   t2;
    logic [31:0]  d32;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        out_ready = 4'b0000;
        drive(0, 4'b0000, 4'b0000, 32'h0, 5'b0, 5'b0, 16'h0);

        //                v  cmd      tag      res           rreg      fb        bd
        //                rdy wv adr   wd            drop port resp  tag   data
        vt[0] = '{0, 4'b0000, 4'b0000, 32'h0,        5'b00000, 5'b00000, 16'h0000,
                  1, 0, 4'h0, 32'h0,        0, -1, 2'b00, 2'b00, 32'h0};
        vt[1] = '{1, 4'b1010, 4'b1001, 32'hDEADBEEF, 5'b10011, 5'b00000, 16'h0000,
                  1, 1, 4'h3, 32'hDEADBEEF, 0, 2, 2'b01, 2'b01, 32'hDEADBEEF};
        vt[2] = '{1, 4'b0101, 4'b0110, 32'h00001234, 5'b10101, 5'b10010, 16'h2000,
                  1, 0, 4'h5, 32'h0,        0, 1, 2'b11, 2'b10, 32'h0};
        vt[3] = '{1, 4'b0011, 4'b0000, 32'h00000099, 5'b10001, 5'b00000, 16'h0000,
                  1, 0, 4'h0, 32'h0,        1, -1, 2'b00, 2'b00, 32'h0};
        vt[4] = '{1, 4'b0110, 4'b1111, 32'h0000A5A5, 5'b11111, 5'b10011, 16'h2000,
                  1, 1, 4'hF, 32'h0000A5A5, 0, 3, 2'b01, 2'b11, 32'h0};
        vt[5] = '{1, 4'b1010, 4'b0000, 32'h00000055, 5'b00111, 5'b00000, 16'h0000,
                  1, 0, 4'h7, 32'h00000055, 0, 0, 2'b01, 2'b00, 32'h00000055};
        vt[6] = '{1, 4'b1001, 4'b0001, 32'h00000077, 5'b10001, 5'b01111, 16'hFFFF,
                  1, 1, 4'h1, 32'h00000077, 0, 0, 2'b01, 2'b01, 32'h0};
        vt[7] = '{0, 4'b0000, 4'b0000, 32'h0,        5'b00000, 5'b00000, 16'h0000,
                  1, 0, 4'h0, 32'h0,        0, -1, 2'b00, 2'b00, 32'h0};

        #3;
        chk("rst_rdy", 128'(in_ready), 128'(1));
        chk_idle("rst_hi");
        #9 reset = 1'b0;
        #1 chk_idle("rst_lo");

        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].v, vt[i].cmd, vt[i].tag, vt[i].res,
                  vt[i].rreg, vt[i].fb, vt[i].bd);
            #1 chk($sformatf("v%0d_rdy", i), 128'(in_ready), 128'(vt[i].e_rdy));
            @(negedge c_clk);
            #2;
            x_ov = '0; x_resp = '0; x_tag = '0; x_data = '0;
            if (vt[i].e_port >= 0) begin
                x_ov[vt[i].e_port]              = 1'b1;
                x_resp[2*vt[i].e_port +: 2]     = vt[i].e_resp;
                x_tag[2*vt[i].e_port +: 2]      = vt[i].e_tag;
                x_data[32*vt[i].e_port +: 32]   = vt[i].e_data;
            end
            chk($sformatf("v%0d_wv", i), 128'(write_valid), 128'(vt[i].e_wv));
            chk($sformatf("v%0d_adr", i), 128'(write_adr), 128'(vt[i].e_adr));
            chk($sformatf("v%0d_wd", i), 128'(write_data), 128'(vt[i].e_wd));
            chk($sformatf("v%0d_drop", i), 128'(drop_cmd), 128'(vt[i].e_drop));
            chk($sformatf("v%0d_ov", i), 128'(out_valid), 128'(x_ov));
            chk($sformatf("v%0d_resp", i), 128'(out_resp), 128'(x_resp));
            chk($sformatf("v%0d_tag", i), 128'(out_tag), 128'(x_tag));
            chk($sformatf("v%0d_data", i), out_data, x_data);
        end

        // Backpressure on port 0: four fit, fifth is refused
        out_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'b1010, {2'b00, 2'(i)}, 32'(100 + i),
                  5'b10010, 5'b00000, 16'h0000);
            #1 chk($sformatf("bp%0d_rdy", i), 128'(in_ready),
                   128'(i < 4 ? 1 : 0));
            @(negedge c_clk);
            #2;
            chk($sformatf("bp%0d_wv", i), 128'(write_valid),
                128'(i < 4 ? 1 : 0));
            chk($sformatf("bp%0d_ov0", i), 128'(out_valid[0]), 128'(1));
        end
        in_valid = 1'b0;
        out_ready[0] = 1'b1;
        #1 chk("bp_nobypass", 128'(in_ready), 128'(0));
        for (int k = 0; k < 4; k++) begin
            t2  = out_tag[0 +: 2];
            d32 = out_data[0 +: 32];
            chk($sformatf("drain%0d_tag", k), 128'(t2), 128'(k));
            chk($sformatf("drain%0d_data", k), 128'(d32), 128'(100 + k));
            @(negedge c_clk);
            #2;
            if (k == 0) chk("drain_rdy", 128'(in_ready), 128'(1));
        end
        chk("drain_empty", 128'(out_valid), 128'(0));

        // Reset with three entries queued on port 1
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b1010, {2'b01, 2'(i)}, 32'(200 + i),
                  5'b10010, 5'b00000, 16'h0000);
            @(negedge c_clk);
            #2;
        end
        in_valid = 1'b0;
        chk("pre_rst_ov1", 128'(out_valid[1]), 128'(1));
        chk("pre_rst_wv", 128'(write_valid), 128'(1));
        reset = 1'b1;
        #1 chk_idle("mid_rst");
        #1 reset = 1'b0;
        out_ready = 4'b0100;
        drive(1, 4'b1010, 4'b0111, 32'h0000CAFE, 5'b00000, 5'b00000, 16'h0000);
        @(negedge c_clk);
        #2;
        in_valid = 1'b0;
        x_ov = 4'b0100;
        chk("post_rst_ov", 128'(out_valid), 128'(x_ov));
        t2  = out_tag[2 +: 2];
        d32 = out_data[32 +: 32];
        chk("post_rst_tag", 128'(t2), 128'(3));
        chk("post_rst_data", 128'(d32), 128'(32'h0000CAFE));
        @(negedge c_clk);
        #2;
        chk("post_rst_empty", 128'(out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_output_queue.md
Name: exec_output_queue

Overview:
- Parametrised successor to the per-unit output stage of the calc3 execution pipe.
- Takes one completed command per cycle from an execution unit (shifter or adder, selected by parameters) and produces a registered register-file write.
- Queues responses in per-requestor FIFOs with a valid/ready handshake, replacing the single-cycle fire-and-forget response.
- Sits between the unit's execute stage and the port response muxes.

Parameters:
NUM_PORTS, 4, number of requestor ports (power of 2, >=2); PW = log2(NUM_PORTS)
TAG_W, 2, per-port sub-tag width
DATA_W, 32, result/data width
REG_ADR_W, 4, register address width
BRANCH_W, 16, branch condition vector width (power of 2); BW = log2(BRANCH_W)
DEPTH, 4, response FIFO entries per port (power of 2, >=2)
VALID_MASK, 16'h0660, bit c (LSB=0) set means cmd value c is valid for this unit; default accepts 0101, 0110, 1001, 1010
DATA_CMD, 4'b1010, cmd value that returns result data to the requestor

Ports:
c_clk  in  1  clock; all state updates on negedge
reset  in  1  asynchronous, active-high
in_valid  in  1  command present
in_ready  out  1  command accepted when in_valid && in_ready
in_cmd  in  4  command code
in_tag  in  PW+TAG_W  bits [0:PW-1] = port, remainder = sub-tag
in_result  in  DATA_W  unit result
in_result_reg  in  1+REG_ADR_W  bit 0 = write enable, rest = address
follow_branch  in  1+BW  bit 0 = conditional, rest = branch_data index
branch_data  in  BRANCH_W  branch condition bits
write_valid  out  1  register write strobe
write_adr  out  REG_ADR_W  register address
write_data  out  DATA_W  register data
out_valid  out  NUM_PORTS  per-port response present
out_ready  in  NUM_PORTS  per-port response consumed
out_resp  out  2*NUM_PORTS  port p at [2p:2p+1]
out_tag  out  TAG_W*NUM_PORTS  sub-tag, port p slice
out_data  out  DATA_W*NUM_PORTS  data, port p slice
drop_cmd  out  1  one-cycle pulse: invalid command discarded

Behaviour:
- All vectors are indexed [0:W-1], bit 0 = MSB.
- Reset (async) clears all FIFOs and counters, write_valid/adr/data, and drop_cmd. All out_* are 0 while reset is high and after it.
- valid = VALID_MASK[in_cmd].
- skip = follow_branch[0] && branch_data[follow_branch[1:BW]].
- port = in_tag[0:PW-1].
- in_ready: 1 if !valid; otherwise !full[port]. It is combinational, and a same-cycle dequeue does not free the slot (no bypass).
- Accepted invalid command: no write, no enqueue; drop_cmd = 1 for the following cycle.
- Accepted valid command, registered at the next negedge:
  - write_valid = in_result_reg[0] && !skip; write_adr = in_result_reg[1:]; write_data = skip ? 0 : in_result.
  - write_* return to 0 the cycle after unless another write occurs; back-to-back accepts produce back-to-back writes.
  - Enqueue {resp, subtag, data} to the FIFO for port, where resp = skip ? 2'b11 : 2'b01, subtag = in_tag[PW:], and data = (!skip && in_cmd == DATA_CMD) ? in_result : 0.
- Per-port FIFO:
  - Read pointer, write pointer, and count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
  - out_valid[p] = count != 0.
  - out_resp/tag/data show the head entry, or 0 when empty.
  - Dequeue on out_valid[p] && out_ready[p]; the next entry appears on the following cycle.
  - Simultaneous enqueue and dequeue on a non-full FIFO leaves count unchanged.
  - out_ready while empty is ignored.
- Latency: accept at negedge N; response visible after negedge N if the FIFO was empty, with the write strobe in the same cycle.
- Order is FIFO per port only; no ordering is guaranteed across ports.
- Reset mid-operation discards all queued responses; no partial write strobe.

Test Plan:
- Reset with no traffic -> in_ready = 1, out_valid = 0000, write_valid = 0, all data 0.
- cmd 1010, tag 10_01, result 32'hDEADBEEF, result_reg 1_0011, no branch -> next cycle: write_valid = 1, adr = 3, data DEADBEEF; out_valid = 0100; port 2 resp = 01, tag = 01, data DEADBEEF; other ports 0.
- cmd 0101, follow_branch 1_0010, branch_data bit 2 = 1 -> write_valid = 0; resp = 11; data = 0.
- cmd 0011 -> in_ready = 1, drop_cmd pulses, no enqueue, no write.
- Five cmds to port 0 with out_ready[0] = 0 -> four accepted, and in_ready = 0 on the fifth. Raise out_ready -> tags drain in issue order 0,1,2,3; in_ready returns one cycle after the first dequeue.
- Three queued entries, assert reset between clocks -> out_valid = 0 immediately; after release, new traffic starts from an empty queue.
